// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: op and state encodings,
// common widths and the legal-STEP check.
package shift_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  function automatic bit step_is_legal(input int unsigned step);
    return (step == 1) || (step == 2) || (step == 4) || (step == 8);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift stage: moves the value by amt_i (0..STEP) positions
// using the fill rule selected by op_i.
module shift_step
  import shift_pkg::*;
#(
  parameter  int unsigned STEP  = 1,
  localparam int unsigned AMT_W = $clog2(STEP + 1)
) (
  input  logic [DATA_W-1:0] value_i,
  input  op_e               op_i,
  input  logic [AMT_W-1:0]  amt_i,
  output logic [DATA_W-1:0] value_o
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    value_o = value_i;
    case (op_i)
      OP_SLL:  value_o = value_i << amt_i;
      OP_SRL:  value_o = value_i >> amt_i;
      OP_SRA:  value_o = DATA_W'($signed(value_i) >>> amt_i);
      default: value_o = value_i;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit: shifts up to STEP positions per clock under a
// start/busy/done handshake; DataOut holds the last completed result.
module shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Start,
  input  logic [1:0]          Op,
  input  logic [DATA_W-1:0]   DataIn,
  input  logic [SHAMT_W-1:0]  Shamt,
  output logic [DATA_W-1:0]   DataOut,
  output logic                Busy,
  output logic                Done
);

  localparam int unsigned AMT_W = $clog2(STEP + 1);

  if (!step_is_legal(STEP)) begin : g_bad_step
    $error("shift_unit: STEP must be 1, 2, 4 or 8");
  end

  state_e               state_q;
  op_e                  op_q;
  logic [DATA_W-1:0]    work_q;
  logic [DATA_W-1:0]    work_d;
  logic [SHAMT_W-1:0]   rem_q;
  logic [SHAMT_W-1:0]   rem_d;
  logic [DATA_W-1:0]    data_out_q;
  logic                 busy_q;
  logic                 done_q;
  logic [AMT_W-1:0]     k;
  logic                 accept;
  logic                 no_shift;

  // k = min(STEP, remaining); when remaining < STEP it fits in AMT_W bits.
  always_comb begin
    k        = (rem_q >= SHAMT_W'(STEP)) ? AMT_W'(STEP) : AMT_W'(rem_q);
    rem_d    = rem_q - SHAMT_W'(k);
    accept   = Start && (state_q != S_SHIFT);
    no_shift = (Shamt == '0) || (op_e'(Op) == OP_PASS);
  end

  shift_step #(
    .STEP (STEP)
  ) u_step (
    .value_i (work_q),
    .op_i    (op_q),
    .amt_i   (k),
    .value_o (work_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_SLL;
      work_q     <= '0;
      rem_q      <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (accept) begin
            work_q <= DataIn;
            rem_q  <= Shamt;
            op_q   <= op_e'(Op);
            if (no_shift) begin
              data_out_q <= DataIn;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            data_out_q <= work_d;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign DataOut = data_out_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule
